// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Central hazard/stall controller for the 5-stage MIPS pipeline.
//   * Forwarding selects for the Execute ALU operands and the Decode branch
//     comparator.
//   * Load-use and branch-operand interlocks (stall F/D, bubble into D/E).
//   * Wait-state FSM that holds the whole front of the pipeline while a
//     multi-cycle data-memory access completes, with a timeout that aborts
//     a hung access (bubble into M/W, sticky MemErr).
//
// Optional feature macro: STALL_PERF_CNT_EN
//   defined   -> StallCycles counts clocks with StallF=1 (saturating)
//   undefined -> StallCycles is constant zero, no counter flops
//
// Ports:
//   CLK, RST                      clock, asynchronous active-low reset
//   RsD, RtD                      source registers in Decode
//   RsE, RtE                      source registers in Execute
//   WriteRegE/M/W                 destination register per stage
//   RegWriteE/M/W                 register-write flag per stage
//   MemtoRegE, MemtoRegM          load in Execute / Memory
//   BranchD                       branch resolving in Decode
//   MemReqM, MemReadyM            data-memory request / completion
//   StallF/D/E/M                  hold enables for PC, F/D, D/E, E/M
//   FlushE, FlushW                bubble into D/E, M/W
//   ForwardAE, ForwardBE          00 regfile, 01 from W, 10 from M
//   ForwardAD, ForwardBD          branch operand from ALUOutM
//   MemErr                        sticky data-memory timeout flag
//   StallCycles                   stall performance counter
// ---------------------------------------------------------------------------
module pipeline_hazard_controller #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [REG_ADDR_WIDTH-1:0] RsD,
  input  logic [REG_ADDR_WIDTH-1:0] RtD,
  input  logic [REG_ADDR_WIDTH-1:0] RsE,
  input  logic [REG_ADDR_WIDTH-1:0] RtE,
  input  logic [REG_ADDR_WIDTH-1:0] WriteRegE,
  input  logic [REG_ADDR_WIDTH-1:0] WriteRegM,
  input  logic [REG_ADDR_WIDTH-1:0] WriteRegW,
  input  logic                      RegWriteE,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic                      MemtoRegE,
  input  logic                      MemtoRegM,
  input  logic                      BranchD,
  input  logic                      MemReqM,
  input  logic                      MemReadyM,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      StallM,
  output logic                      FlushE,
  output logic                      FlushW,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      ForwardAD,
  output logic                      ForwardBD,
  output logic                      MemErr,
  output logic [31:0]               StallCycles
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  state_t                 state_reg;
  logic [CNT_WIDTH-1:0]   cnt_reg;
  logic                   mem_err_reg;
  logic                   flush_w_reg;

  // Index 0 = Rs operand, index 1 = Rt operand.
  logic [REG_ADDR_WIDTH-1:0] src_d [2];
  logic [REG_ADDR_WIDTH-1:0] src_e [2];
  logic [1:0]                fwd_e [2];
  logic                      fwd_d [2];
  logic                      match_de [2];  // Decode source vs WriteRegE
  logic                      match_dm [2];  // Decode source vs WriteRegM

  assign src_d[0] = RsD;
  assign src_d[1] = RtD;
  assign src_e[0] = RsE;
  assign src_e[1] = RtE;

  // Register 0 is hard-wired to zero, so a zero source address never
  // matches anything: no forward and no interlock for it.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      logic src_e_nz;
      logic src_d_nz;

      assign src_e_nz = (src_e[gi] != '0);
      assign src_d_nz = (src_d[gi] != '0);

      // Memory stage holds the younger result, so it wins over Writeback.
      assign fwd_e[gi] = (src_e_nz && RegWriteM && (WriteRegM == src_e[gi])) ? 2'b10 :
                         (src_e_nz && RegWriteW && (WriteRegW == src_e[gi])) ? 2'b01 :
                                                                               2'b00;

      assign match_de[gi] = src_d_nz && (WriteRegE == src_d[gi]);
      assign match_dm[gi] = src_d_nz && (WriteRegM == src_d[gi]);
      assign fwd_d[gi]    = RegWriteM && match_dm[gi];
    end
  endgenerate

  assign ForwardAE = fwd_e[0];
  assign ForwardBE = fwd_e[1];
  assign ForwardAD = fwd_d[0];
  assign ForwardBD = fwd_d[1];

  logic lwstall;
  logic brstall;
  logic memstall;
  logic hazstall;

  assign lwstall = MemtoRegE && (match_de[0] || match_de[1]);
  assign brstall = BranchD &&
                   ((RegWriteE && (match_de[0] || match_de[1])) ||
                    (MemtoRegM && (match_dm[0] || match_dm[1])));

  // The stall is combinational on MemReadyM so it drops in the very cycle
  // the memory completes; an N-cycle access therefore costs N-1 stalls.
  // Qualifying with RST lets the stalls fall the moment reset asserts.
  assign memstall = RST &&
                    (((state_reg == ST_IDLE) && MemReqM && !MemReadyM) ||
                     ((state_reg == ST_WAIT) && !MemReadyM && (cnt_reg < TIMEOUT_CNT)));

  // A memory hold freezes everything, so the load-use/branch bubble must
  // not be injected underneath it.
  assign hazstall = RST && !memstall && (lwstall || brstall);

  assign StallF = memstall || hazstall;
  assign StallD = memstall || hazstall;
  assign StallE = memstall;
  assign StallM = memstall;
  assign FlushE = hazstall;
  assign FlushW = flush_w_reg;
  assign MemErr = mem_err_reg;

  // Wait-state FSM. flush_w_reg is raised on the WAIT->ABORT edge so it is
  // high for exactly the ABORT cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      mem_err_reg <= 1'b0;
      flush_w_reg <= 1'b0;
    end else begin
      flush_w_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (MemReqM && !MemReadyM) begin
            state_reg <= ST_WAIT;
            cnt_reg   <= CNT_WIDTH'(1);
          end
        end
        ST_WAIT: begin
          if (MemReadyM) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
          end else if (cnt_reg >= TIMEOUT_CNT) begin
            state_reg   <= ST_ABORT;
            flush_w_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_WIDTH'(1);
          end
        end
        ST_ABORT: begin
          mem_err_reg <= 1'b1;
          state_reg   <= ST_IDLE;
          cnt_reg     <= '0;
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cycles_reg <= 32'd0;
    end else if (StallF && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end
  end

  assign StallCycles = stall_cycles_reg;
`else
  assign StallCycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_controller
//
// Self-checking bench: a table of combinational hazard/forwarding vectors
// with hand-computed expectations, followed by directed multi-cycle
// sequences for the memory wait FSM (zero-wait, N-cycle wait, timeout,
// reset during a wait). Inputs change on the falling edge and outputs are
// sampled 1 ns later, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

  localparam int AW = 5;
  localparam int TO = 16;

`ifdef STALL_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic [AW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic          RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD;
  logic          MemReqM, MemReadyM;
  logic          StallF, StallD, StallE, StallM, FlushE, FlushW;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          ForwardAD, ForwardBD, MemErr;
  logic [31:0]   StallCycles;

  always #5 CLK = ~CLK;

  pipeline_hazard_controller #(
    .REG_ADDR_WIDTH(AW),
    .MEM_TIMEOUT   (TO),
    .CNT_WIDTH     (5)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RsD        (RsD),
    .RtD        (RtD),
    .RsE        (RsE),
    .RtE        (RtE),
    .WriteRegE  (WriteRegE),
    .WriteRegM  (WriteRegM),
    .WriteRegW  (WriteRegW),
    .RegWriteE  (RegWriteE),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .MemtoRegE  (MemtoRegE),
    .MemtoRegM  (MemtoRegM),
    .BranchD    (BranchD),
    .MemReqM    (MemReqM),
    .MemReadyM  (MemReadyM),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushE     (FlushE),
    .FlushW     (FlushW),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .ForwardAD  (ForwardAD),
    .ForwardBD  (ForwardBD),
    .MemErr     (MemErr),
    .StallCycles(StallCycles)
  );

  typedef struct {
    logic [AW-1:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
    logic          rw_e, rw_m, rw_w, m2r_e, m2r_m, br_d;
    logic          exp_stall;   // StallF and StallD
    logic          exp_flush_e;
    logic [1:0]    exp_fae, exp_fbe;
    logic          exp_fad, exp_fbd;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; MemtoRegM = 1'b0; BranchD = 1'b0;
    MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    RsD = v.rs_d; RtD = v.rt_d; RsE = v.rs_e; RtE = v.rt_e;
    WriteRegE = v.wr_e; WriteRegM = v.wr_m; WriteRegW = v.wr_w;
    RegWriteE = v.rw_e; RegWriteM = v.rw_m; RegWriteW = v.rw_w;
    MemtoRegE = v.m2r_e; MemtoRegM = v.m2r_m; BranchD = v.br_d;
    MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic set_load_use(input logic on);
    MemtoRegE = on;
    WriteRegE = on ? 5'd9 : 5'd0;
    RtD       = on ? 5'd9 : 5'd0;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RST = 1'b0;
    #2;
    RST = 1'b1;
  endtask

  int exp_perf;
  int stall_vecs;

  initial begin
    // Fields: rs_d rt_d rs_e rt_e wr_e wr_m wr_w | rw_e rw_m rw_w m2r_e m2r_m br_d |
    //         stall flushE fAE fBE fAD fBD
    vecs[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[1]  = '{5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 5'd8, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0};
    vecs[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[3]  = '{5'd0, 5'd0, 5'd6, 5'd5, 5'd0, 5'd6, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, 1'b0};
    vecs[4]  = '{5'd0, 5'd0, 5'd5, 5'd5, 5'd0, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0};
    vecs[5]  = '{5'd3, 5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
    vecs[6]  = '{5'd0, 5'd9, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[8]  = '{5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[9]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1};
    vecs[10] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1};
    vecs[11] = '{5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[13] = '{5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[14] = '{5'd2, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};

    // ---------------- reset state (hazards present while in reset) -------
    clear_inputs();
    RST = 1'b0;
    MemReqM = 1'b1;
    set_load_use(1'b1);
    #2;
    chk("reset StallF", {31'd0, StallF}, 32'd0);
    chk("reset StallE", {31'd0, StallE}, 32'd0);
    chk("reset FlushE", {31'd0, FlushE}, 32'd0);
    chk("reset FlushW", {31'd0, FlushW}, 32'd0);
    chk("reset MemErr", {31'd0, MemErr}, 32'd0);
    chk("reset StallCycles", StallCycles, 32'd0);
    $display("reset: StallF=%0b FlushE=%0b MemErr=%0b", StallF, FlushE, MemErr);
    @(negedge CLK);
    clear_inputs();
    @(negedge CLK);
    RST = 1'b1;

    // ---------------- table-driven combinational vectors -----------------
    stall_vecs = 0;
    for (int i = 0; i < NVEC; i++) begin
      @(negedge CLK);
      apply_vec(vecs[i]);
      #1;
      chk($sformatf("v%0d StallF", i), {31'd0, StallF}, {31'd0, vecs[i].exp_stall});
      chk($sformatf("v%0d StallD", i), {31'd0, StallD}, {31'd0, vecs[i].exp_stall});
      chk($sformatf("v%0d StallE", i), {31'd0, StallE}, 32'd0);
      chk($sformatf("v%0d StallM", i), {31'd0, StallM}, 32'd0);
      chk($sformatf("v%0d FlushE", i), {31'd0, FlushE}, {31'd0, vecs[i].exp_flush_e});
      chk($sformatf("v%0d FlushW", i), {31'd0, FlushW}, 32'd0);
      chk($sformatf("v%0d ForwardAE", i), {30'd0, ForwardAE}, {30'd0, vecs[i].exp_fae});
      chk($sformatf("v%0d ForwardBE", i), {30'd0, ForwardBE}, {30'd0, vecs[i].exp_fbe});
      chk($sformatf("v%0d ForwardAD", i), {31'd0, ForwardAD}, {31'd0, vecs[i].exp_fad});
      chk($sformatf("v%0d ForwardBD", i), {31'd0, ForwardBD}, {31'd0, vecs[i].exp_fbd});
      if (vecs[i].exp_stall) stall_vecs++;
      $display("vec %0d: Stall=%0b%0b%0b%0b FlushE=%0b FAE=%b FBE=%b FAD=%0b FBD=%0b",
               i, StallF, StallD, StallE, StallM, FlushE, ForwardAE, ForwardBE, ForwardAD, ForwardBD);
    end
    @(negedge CLK);
    clear_inputs();
    #1;
    exp_perf = PERF_EN ? stall_vecs : 0;
    chk("perf after vectors", StallCycles, 32'(exp_perf));
    $display("perf after vectors: StallCycles=%0d", StallCycles);

    // ---------------- zero-wait access and stray MemReadyM ----------------
    @(negedge CLK);
    MemReqM = 1'b1; MemReadyM = 1'b1;
    #1;
    chk("zero-wait StallF", {31'd0, StallF}, 32'd0);
    chk("zero-wait StallM", {31'd0, StallM}, 32'd0);
    $display("zero-wait: StallF=%0b StallM=%0b", StallF, StallM);
    @(negedge CLK);
    MemReqM = 1'b0; MemReadyM = 1'b1;
    #1;
    chk("stray ready StallM", {31'd0, StallM}, 32'd0);
    $display("stray ready: StallM=%0b", StallM);
    @(negedge CLK);
    MemReadyM = 1'b0;
    #1;
    chk("idle after zero-wait StallM", {31'd0, StallM}, 32'd0);
    $display("idle check: StallM=%0b", StallM);

    // ---------------- 4-cycle access, load-use hidden under the hold -----
    pulse_reset();
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      MemReqM = 1'b1;
      MemReadyM = (c == 4);
      set_load_use(c == 2);
      #1;
      chk($sformatf("wait c%0d StallF", c), {31'd0, StallF}, {31'd0, (c < 4)});
      chk($sformatf("wait c%0d StallD", c), {31'd0, StallD}, {31'd0, (c < 4)});
      chk($sformatf("wait c%0d StallE", c), {31'd0, StallE}, {31'd0, (c < 4)});
      chk($sformatf("wait c%0d StallM", c), {31'd0, StallM}, {31'd0, (c < 4)});
      chk($sformatf("wait c%0d FlushE", c), {31'd0, FlushE}, 32'd0);
      $display("mem wait cycle %0d: Stall=%0b%0b%0b%0b FlushE=%0b", c, StallF, StallD, StallE, StallM, FlushE);
    end
    @(negedge CLK);
    clear_inputs();
    #1;
    chk("after wait StallM", {31'd0, StallM}, 32'd0);
    exp_perf = PERF_EN ? 3 : 0;
    chk("perf after wait", StallCycles, 32'(exp_perf));
    $display("after wait: StallM=%0b StallCycles=%0d", StallM, StallCycles);

    // ---------------- timeout: memory never answers -----------------------
    for (int c = 1; c <= 21; c++) begin
      @(negedge CLK);
      MemReqM = (c <= 17);
      MemReadyM = 1'b0;
      #1;
      chk($sformatf("timeout c%0d StallF", c), {31'd0, StallF}, {31'd0, (c <= 16)});
      chk($sformatf("timeout c%0d StallM", c), {31'd0, StallM}, {31'd0, (c <= 16)});
      chk($sformatf("timeout c%0d FlushW", c), {31'd0, FlushW}, {31'd0, (c == 18)});
      if (c != 18)
        chk($sformatf("timeout c%0d MemErr", c), {31'd0, MemErr}, {31'd0, (c >= 19)});
      $display("timeout cycle %0d: StallF=%0b StallM=%0b FlushW=%0b MemErr=%0b", c, StallF, StallM, FlushW, MemErr);
    end
    exp_perf = PERF_EN ? 3 + TO : 0;
    chk("perf after timeout", StallCycles, 32'(exp_perf));
    $display("after timeout: StallCycles=%0d", StallCycles);

    // ---------------- reset asserted in the 2nd wait cycle ----------------
    @(negedge CLK);
    MemReqM = 1'b1; MemReadyM = 1'b0;
    #1;
    chk("rst-wait c1 StallM", {31'd0, StallM}, 32'd1);
    @(negedge CLK);
    #1;
    chk("rst-wait c2 StallM", {31'd0, StallM}, 32'd1);
    #1;
    RST = 1'b0;
    #1;
    chk("rst-wait StallF", {31'd0, StallF}, 32'd0);
    chk("rst-wait StallM", {31'd0, StallM}, 32'd0);
    chk("rst-wait FlushW", {31'd0, FlushW}, 32'd0);
    chk("rst-wait MemErr", {31'd0, MemErr}, 32'd0);
    chk("rst-wait StallCycles", StallCycles, 32'd0);
    $display("reset mid-wait: StallF=%0b StallM=%0b MemErr=%0b StallCycles=%0d", StallF, StallM, MemErr, StallCycles);
    MemReqM = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("post-reset idle StallM", {31'd0, StallM}, 32'd0);
    @(negedge CLK);
    #1;
    chk("post-reset idle StallM 2", {31'd0, StallM}, 32'd0);
    $display("post-reset: StallM=%0b", StallM);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
